// File: rtl/muldiv_pkg.sv
// Shared M-extension definitions: opcode encodings, FSM state type and decode helpers.
// The ALU decoder uses the same opcode constants.
package muldiv_pkg;

    localparam logic [4:0] OP_MUL    = 5'b01000;
    localparam logic [4:0] OP_MULH   = 5'b01001;
    localparam logic [4:0] OP_MULHSU = 5'b01010;
    localparam logic [4:0] OP_MULHU  = 5'b01011;
    localparam logic [4:0] OP_DIV    = 5'b01100;
    localparam logic [4:0] OP_DIVU   = 5'b01101;
    localparam logic [4:0] OP_REM    = 5'b01110;
    localparam logic [4:0] OP_REMU   = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    // Every M opcode is of the form 01xxx; bit 2 selects divide, bit 1 selects remainder.
    function automatic logic is_m_op(input logic [4:0] op);
        return op[4:3] == 2'b01;
    endfunction

    function automatic logic is_signed_div(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage connection between the ID/EX register and the multiply/divide unit.
interface ex_muldiv_unit_if;

    logic        IN_VALID;
    logic [4:0]  IN_ALU_OP;
    logic [31:0] IN_DATA1;
    logic [31:0] IN_DATA2;
    logic [31:0] OUT_RESULT;
    logic        OUT_BUSY;
    logic        OUT_DONE;

    modport master (
        output IN_VALID, IN_ALU_OP, IN_DATA1, IN_DATA2,
        input  OUT_RESULT, OUT_BUSY, OUT_DONE
    );

    modport slave (
        input  IN_VALID, IN_ALU_OP, IN_DATA1, IN_DATA2,
        output OUT_RESULT, OUT_BUSY, OUT_DONE
    );

endinterface

// File: rtl/ex_muldiv_unit_div_core.sv
// Radix-2 restoring divider on unsigned 32-bit magnitudes, one quotient bit per step.
// The next-step quotient/remainder are exposed so the owner can capture the final step.
module div_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient_next,
    output logic [31:0] remainder_next,
    output logic [4:0]  count
);

    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dsr_q;
    logic [32:0] partial;
    logic [32:0] trial;

    // The remainder stays below the divisor, so the shifted partial fits in 33 bits.
    assign partial = {rem_q, quo_q[31]};
    assign trial   = partial - {1'b0, dsr_q};

    always_comb begin
        quotient_next  = {quo_q[30:0], 1'b0};
        remainder_next = partial[31:0];
        if (!trial[32]) begin
            quotient_next  = {quo_q[30:0], 1'b1};
            remainder_next = trial[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            count <= '0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
            count <= '0;
        end else if (step) begin
            quo_q <= quotient_next;
            rem_q <= remainder_next;
            count <= count + 5'd1;
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M unit: single-cycle multiply, 32-step iterative divide, stalls the
// pipeline through OUT_BUSY and pulses OUT_DONE for one cycle with the result.
module ex_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic CLK,
    input  logic RESET,
    ex_muldiv_unit_if.slave bus
);

    state_t      state;
    state_t      state_next;
    logic [4:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;

    logic        busy;
    logic        done;
    logic        div_start;
    logic        div_step;
    logic [31:0] quotient_next;
    logic [31:0] remainder_next;
    logic [4:0]  div_count;

    // Decode of the live ID/EX instruction (only meaningful while idle).
    logic        accept;
    logic        in_is_div;
    logic        in_is_rem;
    logic        in_signed;
    logic        div_by_zero;
    logic        overflow;
    logic        special;
    logic [31:0] special_res;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    assign accept      = (state == ST_IDLE) && bus.IN_VALID && is_m_op(bus.IN_ALU_OP);
    assign in_is_div   = bus.IN_ALU_OP[2];
    assign in_is_rem   = bus.IN_ALU_OP[1];
    assign in_signed   = is_signed_div(bus.IN_ALU_OP);
    assign div_by_zero = (bus.IN_DATA2 == '0);
    assign overflow    = in_signed && (bus.IN_DATA1 == 32'h8000_0000) && (bus.IN_DATA2 == '1);
    assign special     = in_is_div && (div_by_zero || overflow);
    assign mag_a       = (in_signed && bus.IN_DATA1[31]) ? -bus.IN_DATA1 : bus.IN_DATA1;
    assign mag_b       = (in_signed && bus.IN_DATA2[31]) ? -bus.IN_DATA2 : bus.IN_DATA2;

    always_comb begin
        if (div_by_zero) begin
            special_res = in_is_rem ? bus.IN_DATA1 : '1;
        end else begin
            special_res = in_is_rem ? '0 : 32'h8000_0000;
        end
    end

    // Multiply on latched operands: sign-extend each side to 64 bits as the opcode demands.
    logic        a_sx;
    logic        b_sx;
    logic [63:0] prod;
    logic [31:0] mul_res;

    assign a_sx    = a_q[31] && ((op_q == OP_MULH) || (op_q == OP_MULHSU));
    assign b_sx    = b_q[31] && (op_q == OP_MULH);
    assign prod    = {{32{a_sx}}, a_q} * {{32{b_sx}}, b_q};
    assign mul_res = (op_q == OP_MUL) ? prod[31:0] : prod[63:32];

    // Quotient negates on differing signs; remainder follows the dividend.
    logic        div_signed;
    logic [31:0] div_res;

    assign div_signed = is_signed_div(op_q);

    always_comb begin
        if (op_q[1]) begin
            div_res = (div_signed && a_q[31]) ? -remainder_next : remainder_next;
        end else begin
            div_res = (div_signed && (a_q[31] ^ b_q[31])) ? -quotient_next : quotient_next;
        end
    end

    div_core u_div_core (
        .clk            (CLK),
        .rst            (RESET),
        .start          (div_start),
        .step           (div_step),
        .dividend       (mag_a),
        .divisor        (mag_b),
        .quotient_next  (quotient_next),
        .remainder_next (remainder_next),
        .count          (div_count)
    );

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        div_start  = 1'b0;
        div_step   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    busy = 1'b1;
                    if (special) begin
                        state_next = ST_DONE;
                    end else if (in_is_div) begin
                        state_next = ST_DIV;
                        div_start  = 1'b1;
                    end else begin
                        state_next = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                busy       = 1'b1;
                state_next = ST_DONE;
            end
            ST_DIV: begin
                busy     = 1'b1;
                div_step = 1'b1;
                if (div_count == 5'd31) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (RESET) begin
            busy = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q <= bus.IN_ALU_OP;
                a_q  <= bus.IN_DATA1;
                b_q  <= bus.IN_DATA2;
            end
            case (state)
                ST_IDLE: if (accept && special) result_q <= special_res;
                ST_MUL:  result_q <= mul_res;
                ST_DIV:  if (div_count == 5'd31) result_q <= div_res;
                default: ;
            endcase
        end
    end

    assign bus.OUT_RESULT = result_q;
    assign bus.OUT_BUSY   = busy;
    assign bus.OUT_DONE   = done;

endmodule
